// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send inhibit, 11-bit frame, ack check.
// Outputs registered one cycle behind their cause; wr_ps2 is only accepted while tx_idle=1.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       rx_en,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1) + 1;
  // START is part of the inhibit window, so RTS itself lasts INHIBIT_CYCLES-1 cycles.
  localparam logic [CW-1:0] INH_LAST = CW'((INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0);
  localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT_CYCLES >= 1) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, ACK, WAITREL, DONE} state_t;

  state_t          state, state_nxt;
  logic [FILTER_LEN-1:0] filt_sr;
  logic            filt_cur, filt_prev, fall;
  logic [8:0]      sr, sr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      n, n_nxt;
  logic            fail, fail_nxt;
  logic            c_oe_nxt, d_oe_nxt, idle_nxt, done_nxt, err_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_sr   <= '1;
      filt_cur  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_sr   <= {filt_sr[FILTER_LEN-2:0], ps2c_in};
      if (&filt_sr)
        filt_cur <= 1'b1;
      else if (~|filt_sr)
        filt_cur <= 1'b0;
      filt_prev <= filt_cur;
    end
  end

  assign fall = filt_prev & ~filt_cur;

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    n_nxt     = n;
    fail_nxt  = fail;
    unique case (state)
      IDLE: begin
        if (wr_ps2) begin
          state_nxt = RTS;
          sr_nxt    = {~^din, din};
          cnt_nxt   = '0;
          n_nxt     = '0;
          fail_nxt  = 1'b0;
        end
      end
      RTS: begin
        if (cnt >= INH_LAST) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      START: begin
        state_nxt = DATA;
        cnt_nxt   = '0;
      end
      DATA, ACK, WAITREL: begin
        cnt_nxt = fall ? '0 : cnt + 1'b1;
        if (cnt >= TO_LAST) begin
          fail_nxt  = 1'b1;
          state_nxt = DONE;
        end else if (state == DATA) begin
          // Shifting in ones means the 10th fall naturally presents the released stop bit.
          if (fall) begin
            sr_nxt = {1'b1, sr[8:1]};
            if (n != 4'hF)
              n_nxt = n + 1'b1;
            if (n == 4'd9)
              state_nxt = ACK;
          end
        end else if (state == ACK) begin
          if (fall) begin
            fail_nxt  = ps2d_in;
            state_nxt = WAITREL;
          end
        end else if (ps2c_in && ps2d_in) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    c_oe_nxt = (state_nxt == RTS) || (state_nxt == START);
    unique case (state_nxt)
      START:   d_oe_nxt = 1'b1;
      DATA:    d_oe_nxt = (state != DATA) ? 1'b1 : (fall ? ~sr[0] : ps2d_oe);
      default: d_oe_nxt = 1'b0;
    endcase
    idle_nxt = (state_nxt == IDLE);
    done_nxt = (state_nxt == DONE);
    err_nxt  = done_nxt & fail_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      n            <= '0;
      fail         <= 1'b0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      rx_en        <= 1'b1;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      sr           <= sr_nxt;
      cnt          <= cnt_nxt;
      n            <= n_nxt;
      fail         <= fail_nxt;
      ps2c_oe      <= c_oe_nxt;
      ps2d_oe      <= d_oe_nxt;
      rx_en        <= idle_nxt;
      tx_idle      <= idle_nxt;
      tx_done_tick <= done_nxt;
      ack_err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector line model plus a behavioural PS/2 device that clocks
// the frame in, acks or not, and can stall; expected frames are queued when a command is issued.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       reset, wr_ps2;
  logic [7:0] din;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, rx_en, tx_idle, tx_done_tick, ack_err;
  logic       dev_c, dev_d;

  always #5 clk = ~clk;

  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = dev_d & ~ps2d_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in), .wr_ps2(wr_ps2),
    .din(din), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .rx_en(rx_en), .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick), .ack_err(ack_err)
  );

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, done_cnt = 0, done_cyc = 0, c_run = 0, c_last = 0, c_runs = 0, orphan = 0;
  int   fall4 = 0;
  logic done_err = 1'b0, done_oe = 1'b0, rx_busy = 1'b1;
  logic [10:0] exp_q[$];
  logic        exp_err_q[$];

  always @(negedge clk) begin
    cyc++;
    if (tx_done_tick === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = ack_err;
      done_oe  = ps2c_oe | ps2d_oe;
    end
    if (ack_err === 1'b1 && tx_done_tick !== 1'b1)
      orphan++;
    if (ps2c_oe === 1'b1)
      c_run++;
    else if (c_run != 0) begin
      c_last = c_run;
      c_runs++;
      c_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic dev_xfer(input int nclk, input bit do_ack, output logic [10:0] bits,
                          output bit synced);
    int w;
    bits   = '1;
    w      = 0;
    while (ps2c_in !== 1'b0 && w < 300) begin step(); w++; end
    while (!(ps2c_in === 1'b1 && ps2d_in === 1'b0) && w < 1000) begin step(); w++; end
    synced = (w < 1000);
    if (synced) begin
      repeat (20) step();
      for (int k = 0; k < nclk; k++) begin
        bits[k] = ps2d_in;
        if (k == 10) begin
          dev_d = ~do_ack;
          repeat (5) step();
        end
        dev_c = 1'b0;
        if (k == 3) fall4 = cyc;
        repeat (HALF) step();
        if (k == 0) rx_busy = rx_en;
        dev_c = 1'b1;
        if (k == 10) begin
          repeat (2) step();
          dev_d = 1'b1;
        end
        repeat (HALF) step();
      end
    end
  endtask

  // mode 0: full transfer, 1: device stalls (watchdog), 2: reset asserted mid-frame
  task automatic send(input logic [7:0] d, input int nclk, input bit do_ack, input bit inj,
                      input int mode);
    logic [10:0] bits, exp;
    logic        e;
    bit          sy;
    int          d0, r0, w, mask;
    d0 = done_cnt;
    r0 = c_runs;
    din    = d;
    wr_ps2 = 1'b1;
    exp_q.push_back({1'b1, ~^d, d, 1'b0});
    exp_err_q.push_back((mode != 0) || !do_ack);
    step();
    wr_ps2 = 1'b0;
    din    = '0;
    if (inj) begin
      repeat (20) step();
      din    = 8'hA5;
      wr_ps2 = 1'b1;
      step();
      wr_ps2 = 1'b0;
      din    = '0;
    end
    dev_xfer(nclk, do_ack, bits, sy);
    chk("dev_sync", sy, 1);
    chk("inhibit_runs", c_runs - r0, 1);
    chk("inhibit_len", c_last, INH);
    chk("rx_en_busy", rx_busy, 0);
    exp  = exp_q.pop_front();
    e    = exp_err_q.pop_front();
    mask = (1 << nclk) - 1;
    chk("frame_bits", bits & mask[10:0], exp & mask[10:0]);
    if (mode == 2) begin
      reset = 1'b0;
      step();
      chk("rst_idle", tx_idle, 1);
      chk("rst_oe", {ps2c_oe, ps2d_oe}, 0);
      chk("rst_rx_en", rx_en, 1);
      chk("rst_no_done", done_cnt - d0, 0);
      reset = 1'b1;
      repeat (TO + 200) step();
      chk("rst_quiet", done_cnt - d0, 0);
    end else begin
      w = 0;
      while (done_cnt == d0 && w < 3 * TO) begin step(); w++; end
      chk("done_once", done_cnt - d0, 1);
      chk("ack_err", done_err, e);
      if (mode == 1) begin
        chk("to_oe_rel", done_oe, 0);
        chk("to_window", (done_cyc - fall4 >= TO) && (done_cyc - fall4 <= TO + FL + 4), 1);
      end
      step();
      chk("idle_after", {tx_idle, rx_en}, 2'b11);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset  = 1'b0;
    wr_ps2 = 1'b0;
    din    = '0;
    dev_c  = 1'b1;
    dev_d  = 1'b1;
    repeat (3) step();
    chk("rst_ps2c_oe", ps2c_oe, 0);
    chk("rst_ps2d_oe", ps2d_oe, 0);
    chk("rst_rx_en", rx_en, 1);
    chk("rst_tx_idle", tx_idle, 1);
    chk("rst_pulses", {tx_done_tick, ack_err}, 0);
    reset = 1'b1;
    step();

    dev_c = 1'b0;
    repeat (30) step();
    chk("idle_dev_clk", {tx_idle, ps2c_oe, ps2d_oe, tx_done_tick}, 4'b1000);
    dev_c = 1'b1;
    repeat (20) step();

    send(8'hED, 11, 1'b1, 1'b0, 0);
    send(8'h01, 11, 1'b1, 1'b0, 0);
    send(8'hFF, 11, 1'b1, 1'b0, 0);
    send(8'h00, 11, 1'b1, 1'b0, 0);
    send(8'h3C, 11, 1'b0, 1'b0, 0);
    send(8'h5A, 11, 1'b1, 1'b1, 0);
    send(8'h96, 4, 1'b1, 1'b0, 1);
    send(8'hC3, 5, 1'b1, 1'b0, 2);

    chk("orphan_ack_err", orphan, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
